// File: rtl/uart_rx.sv
// 8N1 UART receiver: start-bit qualification at mid-bit, 8 data bits LSB first,
// a one-byte holding register with read strobe, and sticky framing/overrun flags.
module uart_rx #(
  parameter int CLK_HZ   = 24_000_000,
  parameter int BIT_RATE = 115_200
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       uart_rxd,
  output logic [7:0] rx_data,
  output logic       rx_valid,
  input  logic       rx_ack,
  output logic       framing_error,
  output logic       overrun,
  input  logic       err_clear,
  output logic       rx_busy,
  output logic [2:0] dbg_state
);

  localparam int CPB   = CLK_HZ / BIT_RATE;
  localparam int HALF  = CPB / 2;
  localparam int CNT_W = (CPB > 2) ? $clog2(CPB) : 1;

  typedef enum logic [2:0] {
    IDLE      = 3'd0,
    START     = 3'd1,
    DATA      = 3'd2,
    STOP      = 3'd3,
    WAIT_HIGH = 3'd4
  } state_t;

  state_t           state_q;
  logic [1:0]       sync_q;
  logic [CNT_W-1:0] cnt_q;
  logic [2:0]       bit_idx_q;
  logic [7:0]       shift_q;
  logic [7:0]       data_q;
  logic             valid_q;
  logic             fe_q;
  logic             ov_q;
  logic             busy_q;
  logic             rxd_s;

  assign rxd_s = sync_q[1];

  // Later non-blocking assignments override earlier ones, so flag sets in the
  // case below take priority over err_clear / rx_ack on the same edge.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q   <= IDLE;
      sync_q    <= 2'b11;
      cnt_q     <= '0;
      bit_idx_q <= '0;
      shift_q   <= '0;
      data_q    <= 8'h00;
      valid_q   <= 1'b0;
      fe_q      <= 1'b0;
      ov_q      <= 1'b0;
      busy_q    <= 1'b0;
    end else begin
      sync_q <= {sync_q[0], uart_rxd};
      if (err_clear) begin
        fe_q <= 1'b0;
        ov_q <= 1'b0;
      end
      if (rx_ack && valid_q) valid_q <= 1'b0;

      case (state_q)
        IDLE: begin
          cnt_q <= '0;
          if (!rxd_s) begin
            state_q <= START;
            busy_q  <= 1'b1;
          end
        end
        START: begin
          cnt_q <= cnt_q + CNT_W'(1);
          if (cnt_q == CNT_W'(HALF - 1)) begin
            cnt_q <= '0;
            if (rxd_s) begin
              state_q <= IDLE;
              busy_q  <= 1'b0;
            end else begin
              state_q   <= DATA;
              bit_idx_q <= '0;
            end
          end
        end
        DATA: begin
          cnt_q <= cnt_q + CNT_W'(1);
          if (cnt_q == CNT_W'(CPB - 1)) begin
            cnt_q   <= '0;
            shift_q <= {rxd_s, shift_q[7:1]};
            if (bit_idx_q == 3'd7) begin
              state_q <= STOP;
            end else begin
              bit_idx_q <= bit_idx_q + 3'd1;
            end
          end
        end
        STOP: begin
          cnt_q <= cnt_q + CNT_W'(1);
          if (cnt_q == CNT_W'(CPB - 1)) begin
            cnt_q <= '0;
            if (rxd_s) begin
              data_q  <= shift_q;
              valid_q <= 1'b1;
              // A read on this same edge frees the register, so no overrun.
              if (valid_q && !rx_ack) ov_q <= 1'b1;
              state_q <= IDLE;
              busy_q  <= 1'b0;
            end else begin
              fe_q    <= 1'b1;
              state_q <= WAIT_HIGH;
            end
          end
        end
        WAIT_HIGH: begin
          cnt_q <= '0;
          if (rxd_s) begin
            state_q <= IDLE;
            busy_q  <= 1'b0;
          end
        end
        default: begin
          state_q <= IDLE;
          cnt_q   <= '0;
          busy_q  <= 1'b0;
        end
      endcase
    end
  end

  assign rx_data       = data_q;
  assign rx_valid      = valid_q;
  assign framing_error = fe_q;
  assign overrun       = ov_q;
  assign rx_busy       = busy_q;
  assign dbg_state     = state_q;

endmodule

// File: doc/uart_rx.md
UART_RX -- requirements
Module: uart_rx

Interface
REQ-001 SHALL have parameter CLK_HZ, default 24_000_000, meaning system clock frequency in Hz.
REQ-002 SHALL have parameter BIT_RATE, default 115_200, meaning serial bit rate in bit/s.
REQ-003 SHALL have port clk  input  1  system clock; sole clock, all state updates on rising edge.
REQ-004 SHALL have port rst  input  1  reset, synchronous and active-high.
REQ-005 SHALL have port uart_rxd  input  1  asynchronous serial line, idle high.
REQ-006 SHALL have port rx_data  output  8  last received byte (holding register).
REQ-007 SHALL have port rx_valid  output  1  holding register contains an unread byte.
REQ-008 SHALL have port rx_ack  input  1  one-cycle read strobe consuming the held byte.
REQ-009 SHALL have port framing_error  output  1  sticky: stop bit sampled low.
REQ-010 SHALL have port overrun  output  1  sticky: byte completed while previous byte unread.
REQ-011 SHALL have port err_clear  input  1  clears framing_error and overrun.
REQ-012 SHALL have port rx_busy  output  1  high whenever the FSM is not in IDLE.

Function
REQ-013 SHALL use frame format 8N1: one start bit (0), 8 data bits LSB first, one stop bit (1).
REQ-014 SHALL define CPB = CLK_HZ / BIT_RATE (integer division, 208 at defaults) and HALF = CPB / 2 (104 at defaults).
REQ-015 SHALL pass uart_rxd through a 2-flop synchronizer; rxd_s below is the second flop output (2-cycle latency).
REQ-016 SHALL use a bit-timing counter sized to hold CPB-1; it resets to 0 on every state transition and on every sample.
REQ-017 SHALL implement states IDLE, START, DATA, STOP, WAIT_HIGH.
REQ-018 IDLE: on the edge T0 at which rxd_s == 0 is seen, go to START.
REQ-019 START: at T0+HALF, sample rxd_s; if 1 (glitch), return to IDLE silently; if 0, go to DATA with bit index 0.
REQ-020 DATA: sample bit i at T0+HALF+(i+1)*CPB into a shift register; after bit 7, go to STOP.
REQ-021 STOP: sample at T0+HALF+9*CPB; if 1, load shift register into rx_data, set rx_valid on that same edge, go to IDLE.
REQ-022 STOP sampled 0: discard the byte, set framing_error, go to WAIT_HIGH; rx_data/rx_valid unchanged.
REQ-023 WAIT_HIGH: remain until rxd_s == 1 (break handling), then go to IDLE.
REQ-024 From IDLE re-entered after a good stop bit, a new start bit SHALL be detectable on the very next cycle (back-to-back frames).
REQ-025 rx_ack while rx_valid == 1 SHALL clear rx_valid on that edge; rx_ack while rx_valid == 0 SHALL have no effect.
REQ-026 A byte completing while rx_valid == 1 and rx_ack == 0 SHALL overwrite rx_data, keep rx_valid = 1, set overrun.
REQ-027 A byte completing on the same edge as rx_ack with rx_valid == 1 SHALL load the new byte, keep rx_valid = 1, and NOT set overrun.
REQ-028 err_clear SHALL clear both sticky flags; if an error event occurs on the same edge, the flag SHALL be set (set wins).
REQ-029 rx_busy SHALL be a registered decode of state != IDLE.

Reset
REQ-030 While rst == 1 at a rising edge: state = IDLE, counter = 0, bit index = 0, shift register = 0, rx_data = 8'h00, rx_valid = 0, framing_error = 0, overrun = 0, rx_busy = 0.
REQ-031 Both synchronizer flops SHALL reset to 1 so that line idle is not seen as a start bit after reset.
REQ-032 Reset asserted mid-frame SHALL abandon the frame with no rx_valid or error flag; reception resumes only at the next falling edge after reset deasserts.

Verification
REQ-033 Defaults, send 0xA5 at 115200 -> rx_valid rises exactly T0+104+9*208 cycles after T0, rx_data = 8'hA5, no error flags.
REQ-034 Low pulse of 50 cycles on idle line -> returns to IDLE at T0+104, rx_valid stays 0, flags stay 0, rx_busy high for 104 cycles.
REQ-035 Send 0x3C with stop bit 0, then hold line low for 3000 cycles -> framing_error = 1, rx_valid = 0, FSM in WAIT_HIGH until line high; next frame 0x55 received correctly.
REQ-036 Send 0x11 then 0x22 back-to-back, no rx_ack -> rx_data = 8'h22, rx_valid = 1, overrun = 1; err_clear -> overrun = 0.
REQ-037 Send 0x11, then 0x22 with rx_ack pulsed exactly on 0x22's stop-sample edge -> rx_data = 8'h22, rx_valid = 1, overrun = 0.
REQ-038 Assert rst during data bit 4 of 0xFF, deassert, send 0x81 -> only one rx_valid event, rx_data = 8'h81, flags 0.
